// File: rtl/dsp_seq_stripper36_pkg.sv
// Shared fifo36 definitions for the DSP sequence stripper: line flag positions,
// FSM state encodings and a small helper for rewriting the SOF flag.
package dsp_seq_stripper36_pkg;

  localparam int DATA_W  = 32;
  localparam int LINE_W  = 36;
  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;
  localparam int OCC_LSB = 34;
  localparam int OCC_MSB = 35;

  localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_SEQ  = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2
  } state_t;

  // Replace the SOF flag of a fifo36 line, leaving occupancy, EOF and data intact.
  function automatic logic [LINE_W-1:0] restamp_sof(input logic [LINE_W-1:0] line,
                                                    input logic sof);
    return {line[OCC_MSB:EOF_BIT], sof, line[DATA_W-1:0]};
  endfunction

endpackage

// File: rtl/dsp_seq_stripper36_setting_reg.sv
// Settings-bus register: holds the last value written to MY_ADDR and flags the
// write in the same cycle so the owner can act on it without extra latency.
module setting_reg #(
  parameter logic [7:0]       MY_ADDR  = 8'd0,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [7:0]       addr,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             changed
);

  logic [WIDTH-1:0] value_q;

  assign changed = strobe && (addr == MY_ADDR);
  // Forward the incoming value during the write so out and changed agree.
  assign out     = changed ? in : value_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= AT_RESET;
    end else if (changed) begin
      value_q <= in;
    end
  end

endmodule

// File: rtl/dsp_seq_stripper36.sv
// Strips and checks the per-packet sequence word ahead of the VRT header and
// forwards the remainder of each packet with SOF moved onto the header line.
module dsp_seq_stripper36
  import dsp_seq_stripper36_pkg::*;
#(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [LINE_W-1:0] inp_data,
  input  logic              inp_valid,
  output logic              inp_ready,
  output logic [LINE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              seq_err,
  output logic [15:0]       seq_err_count,
  output logic [31:0]       pkt_count
);

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] expected_q;
  logic              resync_q;
  logic              seq_err_q;
  logic [15:0]       seq_err_count_q;
  logic [31:0]       pkt_count_q;

  logic              exp_hit;
  logic [DATA_W-1:0] exp_wr_data;
  logic              cnt_clr_hit;
  logic              cnt_clr_unused;

  logic              in_sof;
  logic              in_eof;
  logic [DATA_W-1:0] seq;
  logic              seq_check;
  logic              seq_mismatch;
  logic              eof_xfer;

  setting_reg #(
    .MY_ADDR (BASE),
    .WIDTH   (32),
    .AT_RESET(32'd0)
  ) u_sr_expected (
    .clk    (clk),
    .rst    (rst),
    .strobe (set_stb),
    .addr   (set_addr),
    .in     (set_data),
    .out    (exp_wr_data),
    .changed(exp_hit)
  );

  // Counter clear is a pure strobe; only the write flag matters.
  setting_reg #(
    .MY_ADDR (BASE + 8'd1),
    .WIDTH   (1),
    .AT_RESET(1'b0)
  ) u_sr_cnt_clear (
    .clk    (clk),
    .rst    (rst),
    .strobe (set_stb),
    .addr   (set_addr),
    .in     (set_data[0]),
    .out    (cnt_clr_unused),
    .changed(cnt_clr_hit)
  );

  assign in_sof = inp_data[SOF_BIT];
  assign in_eof = inp_data[EOF_BIT];
  assign seq    = inp_data[DATA_W-1:0];

  always_comb begin
    state_d   = state_q;
    inp_ready = 1'b1;
    out_valid = 1'b0;
    out_data  = restamp_sof(inp_data, 1'b0);
    seq_check = 1'b0;
    eof_xfer  = 1'b0;
    unique case (state_q)
      S_SEQ: begin
        // Lines without SOF and SOF+EOF runts are swallowed here.
        if (inp_valid && in_sof && !in_eof) begin
          seq_check = 1'b1;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        out_valid = inp_valid;
        inp_ready = out_ready;
        out_data  = restamp_sof(inp_data, 1'b1);
        if (inp_valid && out_ready) begin
          eof_xfer = in_eof;
          state_d  = in_eof ? S_SEQ : S_BODY;
        end
      end
      S_BODY: begin
        out_valid = inp_valid;
        inp_ready = out_ready;
        if (inp_valid && out_ready && in_eof) begin
          eof_xfer = 1'b1;
          state_d  = S_SEQ;
        end
      end
      default: state_d = S_SEQ;
    endcase
  end

  assign seq_mismatch = seq_check && !resync_q && (seq != expected_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SEQ;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= clr ? S_SEQ : state_d;
      seq_err_q <= seq_mismatch && !clr;
    end
  end

  // A settings write wins over the post-check update of the expected value.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q <= '0;
      resync_q   <= 1'b1;
    end else begin
      if (exp_hit) begin
        expected_q <= exp_wr_data;
      end else if (seq_check && !clr) begin
        expected_q <= seq + 32'd1;
      end
      if (clr) begin
        resync_q <= 1'b1;
      end else if (exp_hit || seq_check) begin
        resync_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_count_q <= '0;
      pkt_count_q     <= '0;
    end else begin
      if (cnt_clr_hit) begin
        seq_err_count_q <= '0;
      end else if (seq_mismatch && !clr && (seq_err_count_q != ERR_COUNT_MAX)) begin
        seq_err_count_q <= seq_err_count_q + 16'd1;
      end
      if (cnt_clr_hit) begin
        pkt_count_q <= '0;
      end else if (eof_xfer && !clr) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
    end
  end

  assign seq_err       = seq_err_q;
  assign seq_err_count = seq_err_count_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_dsp_seq_stripper36.sv
// Randomised scoreboard bench for dsp_seq_stripper36: a packet-level model
// predicts forwarded lines, sequence errors and counters.
module tb_dsp_seq_stripper36;

  localparam logic [7:0] BASE = 8'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [35:0] inp_data = '0;
  logic        inp_valid = 1'b0;
  logic        inp_ready;
  logic [35:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        seq_err;
  logic [15:0] seq_err_count;
  logic [31:0] pkt_count;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [35:0] exp_q[$];

  logic [31:0] m_exp = 32'd0;
  bit          m_resync = 1'b1;
  int          m_err_count = 0;
  int          m_pulses = 0;
  logic [31:0] m_pkt_count = 32'd0;

  dsp_seq_stripper36 #(.BASE(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .set_stb      (set_stb),
    .set_addr     (set_addr),
    .set_data     (set_data),
    .inp_data     (inp_data),
    .inp_valid    (inp_valid),
    .inp_ready    (inp_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .seq_err      (seq_err),
    .seq_err_count(seq_err_count),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  // Downstream accepts roughly half the time.
  always begin
    @(posedge clk);
    #2;
    out_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (seq_err === 1'b1) err_pulses++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output actual=%0h expected=none", out_data);
      end else begin
        checkOutput("out_line", {28'd0, out_data}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic sendLine(input logic [35:0] line);
    bit hs;
    bit ok;
    ok = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    inp_data  = line;
    inp_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hs = inp_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    inp_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  // Issues one packet: a sequence line followed by nbody forwarded lines.
  task automatic applyStimulus(input logic [31:0] seq, input int nbody, input int stray_idx);
    logic [35:0] body[$];
    logic [31:0] d;
    logic [1:0]  occ;
    bit          eof;
    bit          exp_err;
    for (int i = 0; i < nbody; i++) begin
      d   = $urandom;
      eof = (i == nbody - 1);
      occ = eof ? 2'($urandom_range(0, 3)) : 2'd0;
      body.push_back({occ, eof, (i == stray_idx), d});
      exp_q.push_back({occ, eof, (i == 0), d});
    end
    exp_err = !m_resync && (seq != m_exp);
    if (exp_err) begin
      m_pulses++;
      if (m_err_count < 65535) m_err_count++;
    end
    m_exp    = seq + 32'd1;
    m_resync = 1'b0;
    m_pkt_count = m_pkt_count + 32'd1;
    sendLine({2'b00, 1'b0, 1'b1, seq});
    checkOutput("seq_err_pulse", {63'd0, seq_err}, {63'd0, exp_err});
    @(posedge clk);
    #1;
    checkOutput("seq_err_width", {63'd0, seq_err}, 64'd0);
    foreach (body[i]) sendLine(body[i]);
  endtask

  task automatic sendRunt();
    sendLine({2'b00, 1'b1, 1'b1, 32'($urandom)});
    checkOutput("runt_no_err", {63'd0, seq_err}, 64'd0);
  endtask

  task automatic sendJunk();
    sendLine({2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 32'($urandom)});
  endtask

  task automatic writeSetting(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
    if (addr == BASE) begin
      m_exp    = data;
      m_resync = 1'b0;
    end else if (addr == BASE + 8'd1) begin
      m_err_count = 0;
      m_pkt_count = 32'd0;
    end
  endtask

  task automatic checkCounts(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) checkOutput({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_err_count"}, 64'(seq_err_count), 64'(m_err_count));
    checkOutput({tag, "_pkt_count"}, 64'(pkt_count), 64'(m_pkt_count));
    checkOutput({tag, "_err_pulses"}, 64'(err_pulses), 64'(m_pulses));
  endtask

  initial begin
    logic [35:0] l;
    int kind;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_inp_ready", {63'd0, inp_ready}, 64'd1);
    checkOutput("rst_seq_err", {63'd0, seq_err}, 64'd0);
    checkOutput("rst_err_count", 64'(seq_err_count), 64'd0);
    checkOutput("rst_pkt_count", 64'(pkt_count), 64'd0);

    applyStimulus(32'd5, 3, -1);
    applyStimulus(32'd6, 3, -1);
    applyStimulus(32'd7, 3, -1);
    checkCounts("in_order");

    writeSetting(BASE, 32'd10);
    applyStimulus(32'd10, 3, -1);
    applyStimulus(32'd12, 3, -1);
    applyStimulus(32'd13, 3, -1);
    checkCounts("gap");

    writeSetting(BASE, 32'd100);
    applyStimulus(32'd100, 2, -1);
    applyStimulus(32'd7, 2, -1);
    applyStimulus(32'd8, 2, -1);
    checkCounts("resync_write");

    sendRunt();
    applyStimulus(m_exp, 2, -1);
    checkCounts("runt");

    applyStimulus(m_exp, 12, 5);
    checkCounts("stray_sof");

    // Packet cut by clr after its first body line.
    sendLine({2'b00, 1'b0, 1'b1, m_exp});
    m_exp    = m_exp + 32'd1;
    m_resync = 1'b0;
    l = {2'b00, 1'b0, 1'b0, 32'($urandom)};
    exp_q.push_back({l[35:33], 1'b1, l[31:0]});
    sendLine(l);
    l = {2'b00, 1'b0, 1'b0, 32'($urandom)};
    exp_q.push_back(l);
    sendLine(l);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_resync = 1'b1;
    applyStimulus(32'($urandom), 3, -1);
    checkCounts("clr");

    writeSetting(BASE + 8'd1, 32'd1);
    checkCounts("cnt_clear");
    checkOutput("cnt_clear_err_zero", 64'(seq_err_count), 64'd0);

    for (int p = 0; p < 30; p++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) sendRunt();
      else if (kind == 1) sendJunk();
      else applyStimulus(($urandom_range(0, 4) == 0) ? 32'($urandom) : m_exp,
                         $urandom_range(1, 6), $urandom_range(1, 5));
    end
    checkCounts("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_seq_stripper36.md
# dsp_seq_stripper36

Fifo36 stage directly downstream of the packet dispatcher's DSP output. It consumes the per-packet 32-bit sequence word that precedes the VRT header and checks it against the expected value, and reports gaps as an error pulse plus a saturating counter. It forwards the rest of the packet unchanged, except that SOF is re-asserted on the VRT header line, and feeds the tx DSP framer.

## Interface
- BASE, 0, settings-bus base address; BASE+0 = resync/expected seq, BASE+1 = counter clear
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- clr  in  1  synchronous flush, active-high
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- inp_data  in  36  {occ[1:0], EOF, SOF, data[31:0]} from the dispatcher DSP output
- inp_valid  in  1  input line valid
- inp_ready  out  1  input line accepted when inp_valid & inp_ready
- out_data  out  36  stripped stream
- out_valid  out  1  output line valid
- out_ready  in  1  downstream ready
- seq_err  out  1  one-cycle pulse on a sequence mismatch
- seq_err_count  out  16  saturating count of mismatches
- pkt_count  out  32  wrapping count of forwarded packets (counted at EOF)

## Operation
- States:
  - S_SEQ: waiting for a sequence line.
  - S_HDR: next line is the VRT header.
  - S_BODY: pass-through.
- S_SEQ:
  - inp_ready=1, out_valid=0.
  - Accepted line without SOF: discard and stay in S_SEQ (resynchronises to a packet boundary).
  - Accepted line with SOF and EOF (runt): discard, stay in S_SEQ, no sequence check, expected value unchanged.
  - Accepted line with SOF and no EOF: run the sequence check, then go to S_HDR.
- Sequence check on seq = inp_data[31:0]:
  - If resync=1 or seq==expected: pass, no error.
  - Otherwise: seq_err pulses and seq_err_count increments, saturating at 16'hFFFF.
  - In both cases expected <= seq+1 (mod 2^32) and resync <= 0.
- S_HDR and S_BODY are combinational pass-through:
  - out_valid=inp_valid, inp_ready=out_ready.
  - out_data = {inp_data[35:33], sof, inp_data[31:0]}, where sof=1 in S_HDR and 0 in S_BODY (any stray input SOF is masked).
- S_HDR: on transfer, go to S_BODY; if that line carries EOF, go to S_SEQ instead.
- S_BODY: on a transfer with EOF, go to S_SEQ.
- Every transferred EOF line increments pkt_count.
- Settings:
  - Write to BASE+0: expected <= set_data, resync <= 0.
  - Write to BASE+1: seq_err_count <= 0, pkt_count <= 0.
  - A settings write on the same cycle as a sequence check takes priority for expected/resync; counter clear takes priority over increment.

## Timing
- Forwarded lines have zero cycles of latency (combinational). The sequence line costs one input cycle and produces no output.
- seq_err is registered: high exactly one cycle, on the cycle after the sequence line is accepted. The counter updates on the same edge.
- out_valid must never depend on out_ready; inp_ready may depend on out_ready.
- Reset values (rst):
  - state S_SEQ, expected 0, resync 1.
  - seq_err 0, seq_err_count 0, pkt_count 0.
  - out_valid 0; inp_ready 1 (S_SEQ).
- clr:
  - state S_SEQ, resync 1, seq_err 0; counters keep their values.
  - A packet cut by clr mid-body leaves downstream without EOF. Downstream is flushed by the same clr.
- Back-to-back packets: EOF accepted in cycle N allows the next sequence line to be accepted in cycle N+1.

## Structure
- Shared fifo36 package/header: flag bit positions (SOF=32, EOF=33, OCC=35:34) and the state encodings S_SEQ/S_HDR/S_BODY.
- Sub-modules: two setting_reg instances (BASE+0 width 32, BASE+1 strobe-only via the changed output). No other sub-modules.
- Target size ~150 lines.

## Test plan
- After reset, send packets with seq 5, then 6, then 7, each 4 lines. Require:
  - 3 output packets of 3 lines each, SOF on the first output line (the VRT header);
  - seq_err never high; pkt_count=3.
- Send seq 10, then 12. Require:
  - seq_err high for one cycle after the seq-12 line is accepted, seq_err_count=1;
  - a following seq 13 passes with no error.
- Write BASE+0=100, then send seq 100 → no error. Then send seq 7 → error, and expected becomes 8.
- Runt: a single line with SOF+EOF, then a 3-line packet with the correct seq. Require:
  - runt produces no output, no error, and pkt_count is unchanged;
  - second packet is forwarded as 2 lines.
- Stream a packet with out_ready toggled randomly at 50% and a stray SOF in mid-body. Require:
  - output data identical to the input body;
  - SOF only on the first output line, EOF preserved, no lines dropped.
- Assert clr mid-body, then send a new packet with an arbitrary seq. Require:
  - no seq_err (resync=1);
  - the packet is forwarded intact;
  - BASE+1 write zeroes both counters.
